// File: rtl/matmul_sequencer.sv
// matmul_sequencer
//   Control FSM that walks a full matrix product C = A x B in row-major order.
//   Each element is computed in three steps. First the A row and B column are
//   read from the operand memories. Next the combinational dot-product result
//   is captured. Finally that result is offered downstream on a valid/ready
//   handshake.
//
// Optional feature (compile-time macro MATMUL_SEQ_PERF_EN):
//   Adds perf_stall_cnt, which counts OUTPUT cycles with res_ready low.
//   The count saturates. It is cleared on accepted start and on reset.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               begin a product (only honoured in IDLE)
//   cfg_rows, cfg_cols  active C dimensions, latched and clamped on start
//   busy, done          busy outside IDLE; done pulses once per product
//   rd_en               operand read strobe to both memories
//   a_row_addr          A row address
//   b_col_addr          B column address
//   dp_result           dot-product datapath output, valid one cycle after rd_en
//   res_valid/res_ready result handshake to the C sink
//   res_data            registered C element
//   res_row, res_col    position of res_data in C
//   perf_stall_cnt      (MATMUL_SEQ_PERF_EN only) downstream stall cycles
module matmul_sequencer #(
    parameter int N    = 32,
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [$clog2(ROWS+1)-1:0]  cfg_rows,
    input  logic [$clog2(COLS+1)-1:0]  cfg_cols,
    output logic                       busy,
    output logic                       done,
    output logic                       rd_en,
    output logic [RW-1:0]              a_row_addr,
    output logic [CW-1:0]              b_col_addr,
    input  logic [N-1:0]               dp_result,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [N-1:0]               res_data,
    output logic [RW-1:0]              res_row,
    output logic [CW-1:0]              res_col
`ifdef MATMUL_SEQ_PERF_EN
    ,
    output logic [31:0]                perf_stall_cnt
`endif
);

    localparam int RCW = $clog2(ROWS + 1);
    localparam int CCW = $clog2(COLS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [RCW-1:0]   rows_q, rows_d;
    logic [CCW-1:0]   cols_q, cols_d;
    logic [RW-1:0]    r_q, r_d;
    logic [CW-1:0]    c_q, c_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rd_en_q, rd_en_d;
    logic             res_valid_q, res_valid_d;
    logic [RW-1:0]    a_row_addr_q, a_row_addr_d;
    logic [CW-1:0]    b_col_addr_q, b_col_addr_d;
    logic [N-1:0]     res_data_q, res_data_d;
    logic [RW-1:0]    res_row_q, res_row_d;
    logic [CW-1:0]    res_col_q, res_col_d;
`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0]      perf_q, perf_d;
`endif

    logic             last_row;
    logic             last_col;

    // Counter widths differ from the latched-count widths, so the counters
    // are zero-extended before they are compared with count-1.
    assign last_row = (RCW'(r_q) == (rows_q - RCW'(1)));
    assign last_col = (CCW'(c_q) == (cols_q - CCW'(1)));

    always_comb begin
        state_d      = state_q;
        rows_d       = rows_q;
        cols_d       = cols_q;
        r_d          = r_q;
        c_d          = c_q;
        res_data_d   = res_data_q;
        res_row_d    = res_row_q;
        res_col_d    = res_col_q;
        a_row_addr_d = a_row_addr_q;
        b_col_addr_d = b_col_addr_q;
`ifdef MATMUL_SEQ_PERF_EN
        perf_d       = perf_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rows_d = (cfg_rows > RCW'(ROWS)) ? RCW'(ROWS) : cfg_rows;
                    cols_d = (cfg_cols > CCW'(COLS)) ? CCW'(COLS) : cfg_cols;
                    r_d    = '0;
                    c_d    = '0;
`ifdef MATMUL_SEQ_PERF_EN
                    perf_d = '0;
`endif
                    if ((rows_d == '0) || (cols_d == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                res_data_d = dp_result;
                res_row_d  = r_q;
                res_col_d  = c_q;
                state_d    = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (res_ready) begin
                    if (last_col && last_row) begin
                        state_d = S_DONE;
                    end else begin
                        if (last_col) begin
                            c_d = '0;
                            r_d = r_q + RW'(1);
                        end else begin
                            c_d = c_q + CW'(1);
                        end
                        state_d = S_READ;
                    end
                end
`ifdef MATMUL_SEQ_PERF_EN
                else if (perf_q != '1) begin
                    perf_d = perf_q + 32'd1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so each one lines up
        // exactly with the state it belongs to.
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        rd_en_d     = (state_d == S_READ);
        res_valid_d = (state_d == S_OUTPUT);
        if (state_d == S_READ) begin
            a_row_addr_d = r_d;
            b_col_addr_d = c_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rows_q       <= '0;
            cols_q       <= '0;
            r_q          <= '0;
            c_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            res_valid_q  <= 1'b0;
            a_row_addr_q <= '0;
            b_col_addr_q <= '0;
            res_data_q   <= '0;
            res_row_q    <= '0;
            res_col_q    <= '0;
`ifdef MATMUL_SEQ_PERF_EN
            perf_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            r_q          <= r_d;
            c_q          <= c_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_en_q      <= rd_en_d;
            res_valid_q  <= res_valid_d;
            a_row_addr_q <= a_row_addr_d;
            b_col_addr_q <= b_col_addr_d;
            res_data_q   <= res_data_d;
            res_row_q    <= res_row_d;
            res_col_q    <= res_col_d;
`ifdef MATMUL_SEQ_PERF_EN
            perf_q       <= perf_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rd_en      = rd_en_q;
    assign res_valid  = res_valid_q;
    assign a_row_addr = a_row_addr_q;
    assign b_col_addr = b_col_addr_q;
    assign res_data   = res_data_q;
    assign res_row    = res_row_q;
    assign res_col    = res_col_q;
`ifdef MATMUL_SEQ_PERF_EN
    assign perf_stall_cnt = perf_q;
`endif

endmodule
